// File: rtl/serial_parity_checker_if.sv
// Serial parity checker bus: the serial bit stream from the upstream mux
// plus the per-frame results returned by the checker.
interface serial_parity_checker_if #(
    parameter int DATA_BITS = 8,
    parameter int ERR_CNT_W = 8
);
    logic                 bit_in;
    logic                 bit_valid;
    logic                 start;
    logic                 busy;
    logic                 frame_done;
    logic                 parity_ok;
    logic                 parity_err;
    logic [DATA_BITS-1:0] data_out;
    logic [ERR_CNT_W-1:0] err_count;

    // Stream source: drives the bits, observes the verdicts.
    modport master (
        output bit_in, bit_valid, start,
        input  busy, frame_done, parity_ok, parity_err, data_out, err_count
    );

    // Checker side: consumes the bits, produces the verdicts.
    modport slave (
        input  bit_in, bit_valid, start,
        output busy, frame_done, parity_ok, parity_err, data_out, err_count
    );
endinterface

// File: rtl/serial_parity_checker.sv
// Serial even-parity checker. Deserialises DATA_BITS data bits (LSB first)
// followed by one even-parity bit, reports the word, a pass/fail verdict
// and a saturating count of failed frames.
module serial_parity_checker #(
    parameter int DATA_BITS = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_parity_checker_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

    state_t               state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic                 par_q,    par_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic [DATA_BITS-1:0] data_q,   data_d;
    logic                 ok_q,     ok_d;
    logic                 perr_q,   perr_d;
    logic                 done_q,   done_d;
    logic [ERR_CNT_W-1:0] errcnt_q, errcnt_d;

    logic frame_ok;

    // Even parity holds when the running data parity matches the parity bit.
    assign frame_ok = ~(par_q ^ bus.bit_in);

    // Next-state and datapath decode; a valid start always opens a new frame.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        shift_d  = shift_q;
        data_d   = data_q;
        ok_d     = ok_q;
        perr_d   = perr_q;
        done_d   = 1'b0;
        errcnt_d = errcnt_q;

        if (bus.bit_valid && bus.start) begin
            // Start (or restart, dropping any partial frame) with data bit 0.
            shift_d = DATA_BITS'(bus.bit_in);
            par_d   = bus.bit_in;
            cnt_d   = CNT_W'(1);
            state_d = (DATA_BITS > 1) ? DATA : PARITY;
        end else if (bus.bit_valid) begin
            case (state_q)
                IDLE: ;  // stray bits outside a frame are discarded
                DATA: begin
                    shift_d = shift_q | (DATA_BITS'(bus.bit_in) << cnt_q);
                    par_d   = par_q ^ bus.bit_in;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(DATA_BITS)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    data_d  = shift_q;
                    ok_d    = frame_ok;
                    perr_d  = ~frame_ok;
                    done_d  = 1'b1;
                    if (!frame_ok && (errcnt_q != '1)) begin
                        errcnt_d = errcnt_q + ERR_CNT_W'(1);
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            shift_q  <= '0;
            data_q   <= '0;
            ok_q     <= 1'b0;
            perr_q   <= 1'b0;
            done_q   <= 1'b0;
            errcnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            ok_q     <= ok_d;
            perr_q   <= perr_d;
            done_q   <= done_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_done = done_q;
    assign bus.parity_ok  = ok_q;
    assign bus.parity_err = perr_q;
    assign bus.data_out   = data_q;
    assign bus.err_count  = errcnt_q;

endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

Serial even-parity checker that sits directly downstream of the 2:1 source-select mux. It consumes the mux's single-bit output as a serial stream of frames. Each frame is DATA_BITS data bits, LSB first, followed by one even-parity bit. Per frame it delivers the deserialised data word, a pass/fail verdict, and a saturating running error count.

## Interface
Parameters:
- DATA_BITS, default 8: data bits per frame, excluding the parity bit; legal range 2..32.
- ERR_CNT_W, default 8: width of the error counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data; driven by the upstream mux output.
- bit_valid  input  1  bit_in is sampled only on edges where bit_valid=1.
- start  input  1  marks the sampled bit as data bit 0 of a new frame; ignored unless bit_valid=1.
- busy  output  1  high while a frame is in progress (DATA or PARITY state).
- frame_done  output  1  one-cycle pulse when a frame completes.
- parity_ok  output  1  verdict of the last completed frame: 1 = total ones in data+parity is even.
- parity_err  output  1  inverse of parity_ok; both are 0 after reset, before any frame completes.
- data_out  output  DATA_BITS  data word of the last completed frame; bit 0 = first received bit.
- err_count  output  ERR_CNT_W  number of failed frames since reset; saturates at all-ones.

## Operation
- FSM states: IDLE, DATA, PARITY.
- IDLE:
  - On bit_valid & start: store bit_in as data bit 0, load running parity = bit_in, set bit counter = 1.
  - If DATA_BITS > 1, go to DATA.
  - Otherwise (guarded; not a legal configuration) go to PARITY.
  - bit_valid without start is discarded.
- DATA:
  - Each bit_valid without start: shift bit_in into position [counter], XOR it into the running parity, increment the counter.
  - When the counter reaches DATA_BITS, go to PARITY.
- PARITY: the next bit_valid without start is the parity bit. On that edge:
  - data_out <= assembled word.
  - parity_ok <= ~(running parity ^ bit_in); parity_err <= its inverse.
  - frame_done <= 1.
  - If the frame failed and err_count is not all-ones, increment err_count.
  - Return to IDLE.
- Restart: bit_valid & start in DATA or PARITY aborts the current frame. That bit becomes data bit 0 of a new frame (same action as in IDLE). The aborted frame produces no frame_done, and data_out, parity_ok and err_count are unchanged.
- Gaps: bit_valid=0 in any state holds all state; there is no timeout.
- busy = (state != IDLE), decoded from registered state.
- Outputs data_out, parity_ok and parity_err hold their values until the next completed frame.
- Partial data is never exposed: the internal shift register is separate from data_out.

## Timing
- All outputs are registered.
- Reset values: state IDLE, busy 0, frame_done 0, parity_ok 0, parity_err 0, data_out 0, err_count 0; the internal counter and running parity are cleared.
- Reset mid-frame: the partial frame is discarded, with no frame_done; all outputs return to their reset values on the next edge.
- Reset has priority over every other input.
- Latency: frame_done, data_out and the verdict become valid in the cycle immediately after the edge that samples the parity bit.
- frame_done is high for exactly one cycle.
- Minimum frame length is DATA_BITS+1 consecutive valid cycles, so back-to-back frames give at most one frame_done per DATA_BITS+1 cycles.
- A start arriving on the edge right after the parity bit is accepted normally, in IDLE. It may coincide with the frame_done cycle.
- busy rises in the cycle after the start bit is sampled and falls in the cycle after the parity bit is sampled.
- err_count updates in the same cycle as frame_done.

## Test plan
- Reset, then frame 0xA5 LSB first with parity bit 0 (four ones) -> one-cycle frame_done, data_out=0xA5, parity_ok=1, parity_err=0, err_count=0.
- Frame 0x07 with parity bit 0 (three ones) -> parity_ok=0, parity_err=1, data_out=0x07, err_count=1. Follow immediately with frame 0x07, parity 1, back-to-back -> parity_ok=1, err_count stays 1.
- Frame 0x3C with random bit_valid gaps of 0-5 cycles -> same result as the gapless case; busy stays high across the gaps; exactly one frame_done.
- Start 0xFF, then assert start again after 4 data bits and send frame 0x12 with parity 0 -> single frame_done with data_out=0x12, parity_ok=1; the aborted frame leaves err_count unchanged.
- Pulse rst after 5 data bits of a frame -> all outputs return to 0 with no frame_done. A following valid frame 0x81, parity 0 -> parity_ok=1.
- ERR_CNT_W=2: send five bad-parity frames -> err_count reads 1, 2, 3, 3, 3.
